// File: rtl/utopia_sched_pkg.sv
// Shared constants and types for the Utopia Level 1 Rx scheduler.
//   CELL_BYTES_DEF : default bytes per ATM cell
//   CNT_W          : byte counter width (covers cells up to 256 bytes)
//   state_e        : scheduler FSM states
package utopia_sched_pkg;

  localparam int unsigned CELL_BYTES_DEF = 53;
  localparam int unsigned CNT_W          = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_XFER  = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after 'last',
// wrapping N-1 -> 0 (the last port itself is checked last).
//   req  : request vector
//   last : index of the previously served port
//   gnt  : granted index (valid when any=1)
//   any  : at least one request present
module rr_arbiter #(
  parameter  int unsigned N  = 8,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] gnt,
  output logic          any
);

  int unsigned idx;

  // Scan offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    gnt = last;
    any = 1'b0;
    idx = 0;
    for (int i = int'(N); i >= 1; i--) begin
      idx = (32'(last) + 32'(i)) % N;
      if (req[IW'(idx)]) begin
        gnt = IW'(idx);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/utopia_rx_sched.sv
// Utopia Level 1 Rx scheduler: round-robin polls NUM_RX PHY ports and
// forwards one full cell at a time (cell-level handshake) to a byte stream.
// Optional statistics counters under `RX_SCHED_STATS_EN.
//   clk, rst                : clock, async active-high reset
//   rx_clav/rx_soc/rx_data  : per-port PHY inputs
//   rx_en                   : per-port read enable, active-low
//   cell_ready              : downstream can take one full cell
//   byte_valid/data/sop/eop : forwarded byte stream (1-cycle latency)
//   byte_port               : source port of current cell
//   byte_abort              : one-cycle pulse, current cell discarded
//   busy                    : FSM not in IDLE
//   cell_cnt/abort_cnt      : saturating counters (RX_SCHED_STATS_EN only)
module utopia_rx_sched
  import utopia_sched_pkg::*;
#(
  parameter  int unsigned NUM_RX     = 8,
  parameter  int unsigned CELL_BYTES = CELL_BYTES_DEF,
  localparam int unsigned PW         = (NUM_RX > 1) ? $clog2(NUM_RX) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_RX-1:0]      rx_clav,
  input  logic [NUM_RX-1:0]      rx_soc,
  input  logic [NUM_RX-1:0][7:0] rx_data,
  output logic [NUM_RX-1:0]      rx_en,
  input  logic                   cell_ready,
  output logic                   byte_valid,
  output logic [7:0]             byte_data,
  output logic                   byte_sop,
  output logic                   byte_eop,
  output logic [PW-1:0]          byte_port,
  output logic                   byte_abort,
  output logic                   busy
`ifdef RX_SCHED_STATS_EN
  ,
  output logic [15:0]            cell_cnt,
  output logic [15:0]            abort_cnt
`endif
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CELL_BYTES - 1);

  state_e            state_q, state_d;
  logic [PW-1:0]     sel_q, sel_d, last_q, last_d, port_d, gnt;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [NUM_RX-1:0] rx_en_d, sel_low;
  logic              any_req, bv_d, sop_d, eop_d, abort_d, soc_bad;
  logic [7:0]        bd_d;

  rr_arbiter #(.N(NUM_RX)) u_arb (
    .req  (rx_clav),
    .last (last_q),
    .gnt  (gnt),
    .any  (any_req)
  );

  assign cnt_inc = cnt_q + CNT_W'(1);
  assign sel_low = ~(NUM_RX'(1) << sel_q);
  // SOC must be set on byte 0 and only on byte 0.
  assign soc_bad = (cnt_q == '0) ? ~rx_soc[sel_q] : rx_soc[sel_q];

  // Next state and next registered outputs; rx_en is computed one cycle ahead.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    port_d  = byte_port;
    rx_en_d = '1;
    bv_d    = 1'b0;
    bd_d    = byte_data;
    sop_d   = 1'b0;
    eop_d   = 1'b0;
    abort_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cell_ready && any_req) begin
          sel_d   = gnt;
          port_d  = gnt;
          rx_en_d = ~(NUM_RX'(1) << gnt);
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        cnt_d   = '0;
        state_d = S_XFER;
        if (LAST_CNT != '0) rx_en_d = sel_low;
      end
      S_XFER: begin
        if (soc_bad) begin
          abort_d = 1'b1;
          last_d  = sel_q;
          state_d = S_IDLE;
        end else begin
          bv_d  = 1'b1;
          bd_d  = rx_data[sel_q];
          sop_d = (cnt_q == '0);
          eop_d = (cnt_q == LAST_CNT);
          if (cnt_q == LAST_CNT) begin
            last_d  = sel_q;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc < LAST_CNT) rx_en_d = sel_low;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      last_q     <= PW'(NUM_RX - 1);
      cnt_q      <= '0;
      rx_en      <= '1;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      byte_sop   <= 1'b0;
      byte_eop   <= 1'b0;
      byte_port  <= '0;
      byte_abort <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      rx_en      <= rx_en_d;
      byte_valid <= bv_d;
      byte_data  <= bd_d;
      byte_sop   <= sop_d;
      byte_eop   <= eop_d;
      byte_port  <= port_d;
      byte_abort <= abort_d;
      busy       <= (state_d != S_IDLE);
    end
  end

`ifdef RX_SCHED_STATS_EN
  // Saturating cell / abort counters, updated with the eop / abort pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cell_cnt  <= '0;
      abort_cnt <= '0;
    end else begin
      if (eop_d && cell_cnt != 16'hFFFF)    cell_cnt  <= cell_cnt + 16'd1;
      if (abort_d && abort_cnt != 16'hFFFF) abort_cnt <= abort_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_utopia_rx_sched.sv
// Directed bench for utopia_rx_sched with a small Utopia L1 PHY model:
// a port presents byte 'ptr' the cycle after its rx_en was low.
module tb_utopia_rx_sched;

  localparam int NRX  = 8;
  localparam int CELL = 53;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRX-1:0]      rx_clav;
  logic [NRX-1:0]      rx_soc;
  logic [NRX-1:0][7:0] rx_data;
  logic [NRX-1:0]      rx_en;
  logic                cell_ready;
  logic                byte_valid;
  logic [7:0]          byte_data;
  logic                byte_sop;
  logic                byte_eop;
  logic [2:0]          byte_port;
  logic                byte_abort;
  logic                busy;
`ifdef RX_SCHED_STATS_EN
  logic [15:0]         cell_cnt;
  logic [15:0]         abort_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  int             ptr [NRX];
  logic [NRX-1:0] en_s;
  bit             inj_en = 1'b0;
  int             inj_port = 0;
  int             inj_idx = 0;

  logic [NRX-1:0] snap_en;
  logic           snap_busy, snap_bv, snap_eop, snap_abort;

  utopia_rx_sched #(.NUM_RX(NRX), .CELL_BYTES(CELL)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_clav    (rx_clav),
    .rx_soc     (rx_soc),
    .rx_data    (rx_data),
    .rx_en      (rx_en),
    .cell_ready (cell_ready),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_sop   (byte_sop),
    .byte_eop   (byte_eop),
    .byte_port  (byte_port),
    .byte_abort (byte_abort),
    .busy       (busy)
`ifdef RX_SCHED_STATS_EN
    ,
    .cell_cnt   (cell_cnt),
    .abort_cnt  (abort_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] cell_byte(input int p, input int k);
    return 8'((p * 37 + k * 5 + 1) & 255);
  endfunction

  function automatic int first_zero(input logic [NRX-1:0] v);
    for (int i = 0; i < NRX; i++) if (!v[i]) return i;
    return -1;
  endfunction

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // PHY model: sample enables mid-cycle, update data just after the edge.
  initial begin
    forever begin
      @(negedge clk);
      en_s = rx_en;
      @(posedge clk);
      #1;
      for (int p = 0; p < NRX; p++) begin
        if (!en_s[p]) begin
          rx_data[p] = cell_byte(p, ptr[p]);
          rx_soc[p]  = (ptr[p] == 0) || (inj_en && p == inj_port && ptr[p] == inj_idx);
          ptr[p]     = (ptr[p] == CELL - 1) ? 0 : ptr[p] + 1;
        end else begin
          rx_soc[p] = 1'b0;
        end
      end
    end
  end

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    snap_en    = rx_en;
    snap_busy  = busy;
    snap_bv    = byte_valid;
    snap_eop   = byte_eop;
    snap_abort = byte_abort;
    step();
    step();
    rst = 1'b0;
    for (int p = 0; p < NRX; p++) ptr[p] = 0;
    inj_en = 1'b0;
  endtask

  // Wait for a grant, then follow the cell to its eop or abort.
  task automatic watch_cell(input int p, input int abort_at);
    int t = 0, nb = 0, low = 0, bad_data = 0, bad_flags = 0, two_low = 0;
    bit got_eop = 1'b0, got_abort = 1'b0;
    while (rx_en == '1 && t < 300) begin
      step();
      t++;
    end
    check_eq("grant_seen", int'(rx_en != '1), 1);
    check_eq("grant_port", first_zero(rx_en), p);
    check_eq("busy_in_cell", int'(busy), 1);
    for (int c = 0; c < 120 && !got_eop && !got_abort; c++) begin
      if ($countones(~rx_en) > 1) two_low++;
      if (!rx_en[p]) low++;
      if (byte_abort) begin
        got_abort = 1'b1;
        if (byte_valid) bad_flags++;
      end else if (byte_valid) begin
        if (byte_data != cell_byte(p, nb)) bad_data++;
        if (byte_sop != (nb == 0)) bad_flags++;
        if (byte_eop != (nb == CELL - 1)) bad_flags++;
        if (int'(byte_port) != p) bad_flags++;
        if (byte_eop) got_eop = 1'b1;
        nb++;
      end
      if (!got_eop && !got_abort) step();
    end
    check_eq("byte_count", nb, (abort_at < 0) ? CELL : abort_at);
    check_eq("en_low_cycles", low, (abort_at < 0) ? CELL : abort_at + 2);
    check_eq("byte_data", bad_data, 0);
    check_eq("byte_flags", bad_flags, 0);
    check_eq("two_en_low", two_low, 0);
    check_eq("eop_seen", int'(got_eop), int'(abort_at < 0));
    check_eq("abort_seen", int'(got_abort), int'(abort_at >= 0));
    check_eq("byte_port", int'(byte_port), p);
  endtask

  initial begin
    int t, nb, bad;
    rst        = 1'b1;
    rx_clav    = '0;
    cell_ready = 1'b0;
    rx_soc     = '0;
    rx_data    = '0;
    for (int p = 0; p < NRX; p++) ptr[p] = 0;
    step();
    step();
    check_eq("rst_rx_en", int'(rx_en), 255);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_valid", int'(byte_valid), 0);
    check_eq("rst_data", int'(byte_data), 0);
    check_eq("rst_port", int'(byte_port), 0);
    check_eq("rst_flags", int'({byte_sop, byte_eop, byte_abort}), 0);
    rst = 1'b0;

    // Single requester on port 3.
    rx_clav    = 8'b0000_1000;
    cell_ready = 1'b1;
    watch_cell(3, -1);
    rx_clav = '0;
    step();
    step();
    step();
    check_eq("idle_rx_en", int'(rx_en), 255);
    check_eq("idle_busy", int'(busy), 0);

    // Round-robin with every port requesting.
    apply_reset();
    rx_clav = '1;
    for (int i = 0; i <= NRX; i++) watch_cell(i % NRX, -1);
    rx_clav = '0;

    // Port 5 raises soc on byte 20; port 6 is next.
    apply_reset();
    inj_en   = 1'b1;
    inj_port = 5;
    inj_idx  = 20;
    rx_clav  = 8'b0110_0000;
    watch_cell(5, 20);
    watch_cell(6, -1);
    rx_clav = '0;
    inj_en  = 1'b0;

    // cell_ready held low for 10 cycles.
    apply_reset();
    rx_clav    = 8'b0000_0100;
    cell_ready = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (rx_en != '1) bad++;
    end
    check_eq("no_grant_wo_ready", bad, 0);
    cell_ready = 1'b1;
    step();
    check_eq("grant_after_ready", int'(rx_en), 8'hFB);
    cell_ready = 1'b0;
    watch_cell(2, -1);
    rx_clav    = '0;
    cell_ready = 1'b1;

    // Reset mid-cell drops the cell and restores port 0 priority.
    apply_reset();
    rx_clav = 8'b0010_0000;
    watch_cell(5, -1);
    rx_clav = 8'b0000_1000;
    t = 0;
    while (rx_en == '1 && t < 300) begin
      step();
      t++;
    end
    check_eq("mid_grant_port", first_zero(rx_en), 3);
    nb = 0;
    t  = 0;
    while (nb < 30 && t < 100) begin
      step();
      t++;
      if (byte_valid) nb++;
    end
    check_eq("mid_bytes", nb, 30);
    rx_clav = 8'b0100_0001;
    apply_reset();
    check_eq("mid_rst_rx_en", int'(snap_en), 255);
    check_eq("mid_rst_busy", int'(snap_busy), 0);
    check_eq("mid_rst_valid", int'(snap_bv), 0);
    check_eq("mid_rst_eop_abort", int'({snap_eop, snap_abort}), 0);
    watch_cell(0, -1);
    rx_clav = '0;

`ifdef RX_SCHED_STATS_EN
    apply_reset();
    rx_clav = 8'b0000_0010;
    for (int i = 0; i < 3; i++) watch_cell(1, -1);
    rx_clav  = 8'b0010_0000;
    inj_en   = 1'b1;
    inj_port = 5;
    inj_idx  = 10;
    watch_cell(5, 10);
    rx_clav = '0;
    step();
    check_eq("cell_cnt", int'(cell_cnt), 3);
    check_eq("abort_cnt", int'(abort_cnt), 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/utopia_rx_sched.md
UTOPIA_RX_SCHED -- requirements
Module: utopia_rx_sched

Interface
REQ-001 SHALL have parameter NUM_RX, default 8, number of Utopia Level 1 Rx ports polled.
REQ-002 SHALL have parameter CELL_BYTES, default 53, bytes per ATM cell.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port rx_clav  input  NUM_RX  per-port cell-available from PHY.
REQ-006 SHALL have port rx_soc  input  NUM_RX  per-port start-of-cell from PHY.
REQ-007 SHALL have port rx_data  input  NUM_RX x 8  per-port cell byte from PHY.
REQ-008 SHALL have port rx_en  output  NUM_RX  per-port read enable, active-low.
REQ-009 SHALL have port cell_ready  input  1  downstream buffer can accept one full cell.
REQ-010 SHALL have port byte_valid  output  1  byte_data valid this cycle.
REQ-011 SHALL have port byte_data  output  8  forwarded cell byte.
REQ-012 SHALL have port byte_sop / byte_eop  output  1 each  first / last byte of cell.
REQ-013 SHALL have port byte_port  output  clog2(NUM_RX)  source port of current cell.
REQ-014 SHALL have port byte_abort  output  1  one-cycle pulse: current cell discarded.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, GRANT, XFER.
REQ-017 IDLE: when cell_ready=1 and any rx_clav=1, SHALL select the first requesting port strictly after last_port (round-robin, wrapping NUM_RX-1 to 0), latch it, and go to GRANT.
REQ-018 GRANT (1 cycle): SHALL drive rx_en[sel]=0; all other rx_en=1; next state XFER with byte count 0.
REQ-019 XFER: SHALL sample rx_data[sel]/rx_soc[sel] every cycle, register them to byte_data/byte_valid with 1-cycle latency, and increment count 0..CELL_BYTES-1.
REQ-020 rx_en[sel] SHALL stay 0 in XFER while count < CELL_BYTES-1 and be 1 in the cycle count = CELL_BYTES-1.
REQ-021 byte_sop SHALL accompany count 0; byte_eop SHALL accompany count CELL_BYTES-1; the FSM then updates last_port=sel and returns to IDLE.
REQ-022 rx_soc[sel]=0 at count 0, or rx_soc[sel]=1 at count>0, SHALL cause: byte_abort pulse (no byte_valid that cycle), all rx_en=1, IDLE; last_port still advances to sel.
REQ-023 rx_clav and cell_ready changes during GRANT/XFER SHALL be ignored (cell-level handshake).
REQ-024 Exactly one rx_en bit SHALL be 0 at any time, or none; never two.
REQ-025 Back-to-back cells SHALL be allowed: IDLE re-arbitrates in the cycle after eop, giving 1 idle cycle minimum between cells.

Reset
REQ-026 rst=1 SHALL asynchronously force IDLE, rx_en all 1, byte_valid/sop/eop/abort/busy 0, byte_data 0, byte_port 0, last_port NUM_RX-1 (port 0 wins first).
REQ-027 rst asserted mid-cell SHALL drop the cell with no byte_eop and no byte_abort.

Configuration
REQ-028 With RX_SCHED_STATS_EN defined, SHALL add outputs cell_cnt (16b) and abort_cnt (16b), incremented on byte_eop / byte_abort, saturating at 16'hFFFF, cleared by rst.
REQ-029 Without RX_SCHED_STATS_EN, those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-030 Package utopia_sched_pkg SHALL hold CELL_BYTES default, the FSM state enum, and the count width constant.
REQ-031 Round-robin selection SHALL be sub-module rr_arbiter (req vector, last pointer in; grant index, any-grant out), purely combinational.

Verification
REQ-032 Port 3 clav=1 only, cell_ready=1 -> rx_en[3]=0 for 53 cycles starting at GRANT, 53 byte_valid, sop on byte 0, eop on byte 52, byte_port=3.
REQ-033 All 8 clav=1 continuously after reset -> cells granted in order 0,1,...,7,0.
REQ-034 Port 5 drives soc=1 at byte 20 -> byte_abort pulse, 20 bytes forwarded, no eop, next grant goes to port 6 if requesting.
REQ-035 clav=1 on port 2, cell_ready=0 for 10 cycles then 1 -> no rx_en low during the 10 cycles; grant in the cycle after cell_ready rises.
REQ-036 rst pulsed at byte 30 -> all rx_en=1 immediately, busy=0, next cell goes to port 0.
REQ-037 With RX_SCHED_STATS_EN: 3 good cells + 1 aborted -> cell_cnt=3, abort_cnt=1.
